// File: rtl/rv_bus_pkg.sv
// Shared types and constants for the instruction/load-store bus arbiter.
package rv_bus_pkg;

   // Arbiter sequencing: pick a winner, run it on the bus, report completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } bus_state_t;

   // Which requester currently owns the bus (also exported for trace/debug).
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } bus_owner_t;

   // Request fields latched from the winner and driven onto the bus.
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } bus_req_t;

   // Read data handed back when the bus never answers.
   localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rv_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory bus. Load/store
// normally wins; a saturating counter forces fetch through after too many
// consecutive load/store grants. Each transfer is bounded by a timeout.
module rv_bus_arbiter
   import rv_bus_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_if_req,
   input  logic [29:0] i_if_addr,
   output logic        o_if_ack,
   output logic        o_if_err,
   output logic [31:0] o_if_rdata,
   input  logic        i_ls_req,
   input  logic        i_ls_write,
   input  logic [31:0] i_ls_addr,
   input  logic [3:0]  i_ls_sel,
   input  logic [31:0] i_ls_wdata,
   output logic        o_ls_ack,
   output logic        o_ls_err,
   output logic [31:0] o_ls_rdata,
   output logic        o_bus_req,
   output logic        o_bus_write,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_bus_sel,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   output logic [1:0]  o_owner
);

   // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam bit            TMO_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

   bus_state_t    state_reg, state_next;
   bus_owner_t    owner_reg, owner_next;
   bus_req_t      req_reg, req_next;
   logic          bus_req_reg, bus_req_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic [3:0]    starve_reg, starve_next;
   logic          if_ack_reg, if_ack_next, if_err_reg, if_err_next;
   logic          ls_ack_reg, ls_ack_next, ls_err_reg, ls_err_next;
   logic [31:0]   if_rdata_reg, if_rdata_next, ls_rdata_reg, ls_rdata_next;
   logic          fetch_wins;

   // Fetch wins when it is alone, or when load/store has starved it long enough.
   assign fetch_wins = i_if_req && (!i_ls_req || (starve_reg == STARVE_MAX));

   // Next-state, grant, timeout and completion logic.
   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      req_next      = req_reg;
      bus_req_next  = bus_req_reg;
      tmo_next      = tmo_reg;
      starve_next   = starve_reg;
      if_ack_next   = 1'b0;
      if_err_next   = 1'b0;
      ls_ack_next   = 1'b0;
      ls_err_next   = 1'b0;
      if_rdata_next = if_rdata_reg;
      ls_rdata_next = ls_rdata_reg;

      case (state_reg)
         IDLE: begin
            if (fetch_wins) begin
               req_next     = '{write: 1'b0, addr: {i_if_addr, 2'b00}, sel: 4'hF, wdata: 32'h0};
               owner_next   = OWN_IF;
               starve_next  = 4'd0;
               bus_req_next = 1'b1;
               tmo_next     = '0;
               state_next   = XFER;
            end else if (i_ls_req) begin
               req_next     = '{write: i_ls_write, addr: i_ls_addr, sel: i_ls_sel, wdata: i_ls_wdata};
               owner_next   = OWN_LS;
               bus_req_next = 1'b1;
               tmo_next     = '0;
               state_next   = XFER;
               if (!i_if_req)
                  starve_next = 4'd0;
               else if (starve_reg != STARVE_MAX)
                  starve_next = starve_reg + 4'd1;
            end else begin
               starve_next = 4'd0;
            end
         end

         XFER: begin
            if (i_bus_ack) begin
               // A real ack beats a timeout landing in the same cycle.
               bus_req_next = 1'b0;
               owner_next   = OWN_NONE;
               state_next   = DONE;
               if (owner_reg == OWN_IF) begin
                  if_ack_next   = 1'b1;
                  if_rdata_next = i_bus_rdata;
               end else begin
                  ls_ack_next   = 1'b1;
                  ls_rdata_next = req_reg.write ? 32'h0 : i_bus_rdata;
               end
            end else if (TMO_EN && (tmo_reg == TMO_LAST)) begin
               bus_req_next = 1'b0;
               owner_next   = OWN_NONE;
               state_next   = DONE;
               if (owner_reg == OWN_IF) begin
                  if_err_next   = 1'b1;
                  if_rdata_next = ERR_DATA;
               end else begin
                  ls_err_next   = 1'b1;
                  ls_rdata_next = ERR_DATA;
               end
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end

         DONE: begin
            // Requesters are still holding the finished request here; skip it.
            state_next = IDLE;
         end

         default: begin
            state_next   = IDLE;
            owner_next   = OWN_NONE;
            bus_req_next = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transfer in flight.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg    <= IDLE;
         owner_reg    <= OWN_NONE;
         req_reg      <= '0;
         bus_req_reg  <= 1'b0;
         tmo_reg      <= '0;
         starve_reg   <= 4'd0;
         if_ack_reg   <= 1'b0;
         if_err_reg   <= 1'b0;
         ls_ack_reg   <= 1'b0;
         ls_err_reg   <= 1'b0;
         if_rdata_reg <= 32'h0;
         ls_rdata_reg <= 32'h0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         req_reg      <= req_next;
         bus_req_reg  <= bus_req_next;
         tmo_reg      <= tmo_next;
         starve_reg   <= starve_next;
         if_ack_reg   <= if_ack_next;
         if_err_reg   <= if_err_next;
         ls_ack_reg   <= ls_ack_next;
         ls_err_reg   <= ls_err_next;
         if_rdata_reg <= if_rdata_next;
         ls_rdata_reg <= ls_rdata_next;
      end
   end

   assign o_if_ack    = if_ack_reg;
   assign o_if_err    = if_err_reg;
   assign o_if_rdata  = if_rdata_reg;
   assign o_ls_ack    = ls_ack_reg;
   assign o_ls_err    = ls_err_reg;
   assign o_ls_rdata  = ls_rdata_reg;
   assign o_bus_req   = bus_req_reg;
   assign o_bus_write = req_reg.write;
   assign o_bus_addr  = req_reg.addr;
   assign o_bus_sel   = req_reg.sel;
   assign o_bus_wdata = req_reg.wdata;
   assign o_owner     = owner_reg;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Self-checking bench for rv_bus_arbiter: directed scenarios plus randomized
// requesters and bus responder, all checked against a transaction-level model.
module tb_rv_bus_arbiter;
   import rv_bus_pkg::*;

   localparam int          SL   = 4;
   localparam int          TMO  = 8;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic        i_clk, i_reset;
   logic        i_if_req;
   logic [29:0] i_if_addr;
   logic        o_if_ack, o_if_err;
   logic [31:0] o_if_rdata;
   logic        i_ls_req, i_ls_write;
   logic [31:0] i_ls_addr, i_ls_wdata;
   logic [3:0]  i_ls_sel;
   logic        o_ls_ack, o_ls_err;
   logic [31:0] o_ls_rdata;
   logic        o_bus_req, o_bus_write;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_sel;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;
   logic [1:0]  o_owner;

   rv_bus_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRD)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .o_if_ack(o_if_ack), .o_if_err(o_if_err), .o_if_rdata(o_if_rdata),
      .i_ls_req(i_ls_req), .i_ls_write(i_ls_write), .i_ls_addr(i_ls_addr),
      .i_ls_sel(i_ls_sel), .i_ls_wdata(i_ls_wdata),
      .o_ls_ack(o_ls_ack), .o_ls_err(o_ls_err), .o_ls_rdata(o_ls_rdata),
      .o_bus_req(o_bus_req), .o_bus_write(o_bus_write), .o_bus_addr(o_bus_addr),
      .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata),
      .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_owner(o_owner)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // ---------------- behavioural model (transaction level) ----------------
   int          m_busy, m_fin, m_owner, m_elapsed, m_starve;
   logic        m_wr;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_sel;
   logic        e_if_ack, e_if_err, e_ls_ack, e_ls_err;
   logic [31:0] e_if_rdata, e_ls_rdata;
   int          m_grants[$];
   int          d_grants[$];
   int          d_prev_owner;

   task automatic model_reset();
      m_busy = 0; m_fin = 0; m_owner = 0; m_elapsed = 0; m_starve = 0;
      e_if_ack = 0; e_if_err = 0; e_ls_ack = 0; e_ls_err = 0;
   endtask

   task automatic model_grant(input int who, input logic wr, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d);
      m_busy = 1; m_owner = who; m_elapsed = 0;
      m_wr = wr; m_addr = a; m_sel = s; m_wdata = d;
      m_grants.push_back(who);
   endtask

   task automatic model_finish(input bit err);
      m_busy = 0; m_fin = 1;
      if (m_owner == 1) begin
         if (err) begin e_if_err = 1; e_if_rdata = ERRD; end
         else     begin e_if_ack = 1; e_if_rdata = i_bus_rdata; end
      end else begin
         if (err) begin e_ls_err = 1; e_ls_rdata = ERRD; end
         else     begin e_ls_ack = 1; e_ls_rdata = m_wr ? 32'h0 : i_bus_rdata; end
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_update();
      if (i_reset) begin
         model_reset();
         return;
      end
      e_if_ack = 0; e_if_err = 0; e_ls_ack = 0; e_ls_err = 0;
      if (m_fin != 0) begin
         m_fin = 0;
      end else if (m_busy != 0) begin
         if (i_bus_ack)                               model_finish(1'b0);
         else if (TMO != 0 && m_elapsed == TMO - 1)   model_finish(1'b1);
         else                                         m_elapsed++;
      end else begin
         if (i_if_req && (!i_ls_req || m_starve == SL)) begin
            model_grant(1, 1'b0, {i_if_addr, 2'b00}, 4'hF, 32'h0);
            m_starve = 0;
         end else if (i_ls_req) begin
            model_grant(2, i_ls_write, i_ls_addr, i_ls_sel, i_ls_wdata);
            if (!i_if_req)          m_starve = 0;
            else if (m_starve < SL) m_starve++;
         end else begin
            m_starve = 0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model once per cycle.
   task automatic compare_all();
      int own_exp;
      own_exp = (m_busy != 0) ? m_owner : 0;
      chk("bus_req", 32'(o_bus_req), 32'(m_busy != 0));
      chk("owner",   32'(o_owner),   32'(own_exp));
      chk("if_ack",  32'(o_if_ack),  32'(e_if_ack));
      chk("if_err",  32'(o_if_err),  32'(e_if_err));
      chk("ls_ack",  32'(o_ls_ack),  32'(e_ls_ack));
      chk("ls_err",  32'(o_ls_err),  32'(e_ls_err));
      if (m_busy != 0) begin
         chk("bus_write", 32'(o_bus_write), 32'(m_wr));
         chk("bus_addr",  o_bus_addr,       m_addr);
         chk("bus_sel",   32'(o_bus_sel),   32'(m_sel));
         chk("bus_wdata", o_bus_wdata,      m_wdata);
      end
      if (e_if_ack || e_if_err) chk("if_rdata", o_if_rdata, e_if_rdata);
      if (e_ls_ack || e_ls_err) chk("ls_rdata", o_ls_rdata, e_ls_rdata);
      if (o_if_ack || o_if_err)
         $display("txn fetch ack=%0b err=%0b rdata=%h t=%0t", o_if_ack, o_if_err, o_if_rdata, $time);
      if (o_ls_ack || o_ls_err)
         $display("txn ldst  ack=%0b err=%0b rdata=%h t=%0t", o_ls_ack, o_ls_err, o_ls_rdata, $time);
      if (o_owner != 2'd0 && d_prev_owner == 0) d_grants.push_back(int'(o_owner));
      d_prev_owner = int'(o_owner);
   endtask

   // ---------------- randomized requesters and bus responder ----------------
   bit auto_en = 0;
   bit if_pend = 0, ls_pend = 0;
   int if_left = 0, ls_left = 0, req_prob = 100;
   int resp_max = 0;
   bit stray_en = 0;
   bit prev_bus_req = 0;
   int resp_delay = 0;

   task automatic run_agents();
      if (if_pend && (o_if_ack || o_if_err)) begin if_pend = 0; i_if_req = 0; end
      if (ls_pend && (o_ls_ack || o_ls_err)) begin ls_pend = 0; i_ls_req = 0; end
      if (!if_pend && if_left > 0 && $urandom_range(0, 99) < req_prob) begin
         if_pend = 1; if_left--; i_if_req = 1; i_if_addr = 30'($urandom);
      end
      if (!ls_pend && ls_left > 0 && $urandom_range(0, 99) < req_prob) begin
         ls_pend = 1; ls_left--; i_ls_req = 1;
         i_ls_write = 1'($urandom); i_ls_addr = $urandom;
         i_ls_sel = 4'($urandom); i_ls_wdata = $urandom;
      end
      if (o_bus_req) begin
         if (!prev_bus_req) resp_delay = $urandom_range(0, resp_max);
         if (resp_delay == 0) begin i_bus_ack = 1; i_bus_rdata = $urandom; end
         else begin i_bus_ack = 0; resp_delay--; end
      end else begin
         i_bus_ack   = stray_en && ($urandom_range(0, 7) == 0);
         i_bus_rdata = $urandom;
      end
      prev_bus_req = o_bus_req;
   endtask

   // One clock: model at the edge, checks and new stimulus just after it.
   task automatic step();
      @(posedge i_clk);
      model_update();
      #1;
      compare_all();
      if (auto_en) run_agents();
   endtask

   task automatic fetch_txn(input logic [29:0] a, input logic [31:0] byte_addr,
                            input logic [31:0] d, input int delay, input string tag);
      i_if_req = 1; i_if_addr = a;
      step();
      chk({tag, "_addr"}, o_bus_addr, byte_addr);
      chk({tag, "_sel"},  32'(o_bus_sel), 32'hF);
      chk({tag, "_own"},  32'(o_owner), 32'd1);
      repeat (delay) step();
      i_bus_ack = 1; i_bus_rdata = d;
      step();
      i_bus_ack = 0;
      chk({tag, "_ack"},   32'(o_if_ack), 32'd1);
      chk({tag, "_rdata"}, o_if_rdata, d);
      chk({tag, "_lsack"}, 32'(o_ls_ack), 32'd0);
      i_if_req = 0;
      step();
      chk({tag, "_ackgone"}, 32'(o_if_ack), 32'd0);
   endtask

   task automatic ls_start(input logic wr, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
      i_ls_req = 1; i_ls_write = wr; i_ls_addr = a; i_ls_sel = s; i_ls_wdata = d;
   endtask

   initial begin
      int n;
      int mi, di;
      int exp_order[7];
      exp_order = '{2, 2, 2, 2, 1, 2, 2};
      d_prev_owner = 0;
      model_reset();
      i_reset = 0; i_if_req = 0; i_if_addr = '0; i_ls_req = 0; i_ls_write = 0;
      i_ls_addr = '0; i_ls_sel = '0; i_ls_wdata = '0; i_bus_ack = 0; i_bus_rdata = '0;
      #1 i_reset = 1;
      model_reset();
      step(); step();
      chk("rst_bus_req", 32'(o_bus_req), 32'd0);
      chk("rst_owner",   32'(o_owner),   32'd0);
      chk("rst_ls_rdata", o_ls_rdata,    32'd0);
      i_reset = 0;
      step();

      // Fetch only, bus answers two cycles after the request appears.
      fetch_txn(30'h400, 32'h0000_1000, 32'h0000_0013, 2, "t1");

      // Simultaneous requests: store goes first, fetch follows.
      i_if_req = 1; i_if_addr = 30'h10;
      ls_start(1'b1, 32'h2004, 4'b0011, 32'h1234);
      step();
      chk("t2_own",   32'(o_owner), 32'd2);
      chk("t2_write", 32'(o_bus_write), 32'd1);
      chk("t2_addr",  o_bus_addr, 32'h2004);
      chk("t2_sel",   32'(o_bus_sel), 32'h3);
      chk("t2_wdata", o_bus_wdata, 32'h1234);
      i_bus_ack = 1; i_bus_rdata = 32'hFFFF_FFFF;
      step();
      i_bus_ack = 0;
      chk("t2_lsack",  32'(o_ls_ack), 32'd1);
      chk("t2_rdata0", o_ls_rdata, 32'd0);
      chk("t2_ifack",  32'(o_if_ack), 32'd0);
      i_ls_req = 0;
      step();
      step();
      chk("t2_if_own",  32'(o_owner), 32'd1);
      chk("t2_if_addr", o_bus_addr, 32'h40);
      i_bus_ack = 1; i_bus_rdata = 32'h0000_0093;
      step();
      i_bus_ack = 0;
      chk("t2_ifack2", 32'(o_if_ack), 32'd1);
      i_if_req = 0;
      step();

      // Bus never answers: eight cycles of request, then an error.
      ls_start(1'b0, 32'h3000, 4'hF, 32'h0);
      step();
      n = 0;
      while (o_bus_req && n < 20) begin n++; step(); end
      chk("t3_req_cycles", 32'(n), 32'd8);
      chk("t3_err",   32'(o_ls_err), 32'd1);
      chk("t3_noack", 32'(o_ls_ack), 32'd0);
      chk("t3_rdata", o_ls_rdata, 32'hDEADBEEF);
      i_ls_req = 0;
      step();

      // Ack exactly on the terminal timeout cycle still completes normally.
      ls_start(1'b0, 32'h3004, 4'hF, 32'h0);
      step();
      repeat (7) step();
      i_bus_ack = 1; i_bus_rdata = 32'h55;
      step();
      i_bus_ack = 0;
      chk("t4_ack",   32'(o_ls_ack), 32'd1);
      chk("t4_noerr", 32'(o_ls_err), 32'd0);
      chk("t4_rdata", o_ls_rdata, 32'h55);
      i_ls_req = 0;
      step();

      // Stray bus acks while idle change nothing.
      i_bus_ack = 1; i_bus_rdata = 32'hBAD0_BAD0;
      step(); step();
      i_bus_ack = 0;
      chk("t5_req",   32'(o_bus_req), 32'd0);
      chk("t5_lsack", 32'(o_ls_ack), 32'd0);
      chk("t5_ifack", 32'(o_if_ack), 32'd0);

      // Requester gives up mid-transfer; the transfer still completes.
      ls_start(1'b0, 32'h5000, 4'hF, 32'h0);
      step();
      i_ls_req = 0;
      step(); step();
      i_bus_ack = 1; i_bus_rdata = 32'h77;
      step();
      i_bus_ack = 1;   // stray during the completion cycle
      chk("t6_ack",   32'(o_ls_ack), 32'd1);
      chk("t6_rdata", o_ls_rdata, 32'h77);
      step();
      i_bus_ack = 0;
      chk("t6_idle_req", 32'(o_bus_req), 32'd0);

      // Reset in the middle of a transfer.
      ls_start(1'b0, 32'h4000, 4'hF, 32'h0);
      step();
      #2 i_reset = 1;
      model_reset();
      #1;
      chk("t7_req_async", 32'(o_bus_req), 32'd0);
      chk("t7_own_async", 32'(o_owner), 32'd0);
      i_ls_req = 0;
      step(); step();
      i_reset = 0;
      step(); step();
      chk("t7_noack", 32'(o_ls_ack | o_ls_err), 32'd0);
      fetch_txn(30'h123, 32'h0000_048C, 32'hCAFE_F00D, 0, "t7f");

      // Starvation guard: fetch held against six back-to-back load/stores.
      mi = m_grants.size(); di = d_grants.size();
      if_left = 1; ls_left = 6; req_prob = 100; resp_max = 0; stray_en = 0;
      auto_en = 1;
      n = 0;
      while ((if_left > 0 || ls_left > 0 || if_pend || ls_pend) && n < 300) begin
         step(); n++;
      end
      chk("t8_done", 32'(if_pend || ls_pend || if_left > 0 || ls_left > 0), 32'd0);
      chk("t8_count", 32'(d_grants.size() - di), 32'd7);
      for (int k = 0; k < 7; k++) begin
         if (d_grants.size() > di + k) chk($sformatf("t8_dut_g%0d", k), 32'(d_grants[di + k]), 32'(exp_order[k]));
         if (m_grants.size() > mi + k) chk($sformatf("t8_mdl_g%0d", k), 32'(m_grants[mi + k]), 32'(exp_order[k]));
      end

      // Randomized traffic with random bus latency, timeouts and stray acks.
      if_left = 300; ls_left = 300; req_prob = 30; resp_max = 11; stray_en = 1;
      n = 0;
      while ((if_left > 0 || ls_left > 0) && n < 20000) begin step(); n++; end
      if_left = 0; ls_left = 0;
      n = 0;
      while ((if_pend || ls_pend) && n < 100) begin step(); n++; end
      chk("drain", 32'(if_pend || ls_pend), 32'd0);
      auto_en = 0;
      i_bus_ack = 0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
